// File: rtl/warp_xrf_mp.sv
// warp_xrf_mp: multi-port integer register file with hardwired-zero r0, write bypass and post-reset clear
//
// Ports:
//   i_clk       clock, all state changes on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_rs_addr   NRD packed read addresses, port k at [k*AW +: AW]
//   o_rs_rdata  NRD packed registered read data, port k at [k*XLEN +: XLEN]
//   i_rd_addr   NWR packed write addresses
//   i_rd_wdata  NWR packed write data
//   i_rd_wen    per-write-port enable
//   o_ready     high once every register r1..r(NREGS-1) has been cleared
module warp_xrf_mp #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NRD*$clog2(NREGS)-1:0] i_rs_addr,
    output logic [NRD*XLEN-1:0]     o_rs_rdata,
    input  logic [NWR*$clog2(NREGS)-1:0] i_rd_addr,
    input  logic [NWR*XLEN-1:0]     i_rd_wdata,
    input  logic [NWR-1:0]          i_rd_wen,
    output logic                    o_ready
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [NRD*XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0]     mem_q [NREGS];
    logic [XLEN-1:0]     mem_d [NREGS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = '0;
        mem_d   = mem_q;
        if (state_q == CLEAR) begin
            mem_d[cnt_q] = '0;
            cnt_d        = cnt_q + 1'b1;
            state_d      = (cnt_q == LAST) ? READY : CLEAR;
        end else begin
            // Address 0 never loads, so r0 reads 0 and is never a bypass target.
            for (int k = 0; k < NRD; k++) begin
                if (i_rs_addr[k*AW +: AW] != '0) begin
                    rdata_d[k*XLEN +: XLEN] = mem_q[i_rs_addr[k*AW +: AW]];
                    // Ascending scan lets the highest-index matching port win, as in commit.
                    for (int j = 0; j < NWR; j++) begin
                        if (BYPASS != 0 && i_rd_wen[j] && i_rd_addr[j*AW +: AW] == i_rs_addr[k*AW +: AW])
                            rdata_d[k*XLEN +: XLEN] = i_rd_wdata[j*XLEN +: XLEN];
                    end
                end
            end
            for (int j = 0; j < NWR; j++) begin
                if (i_rd_wen[j] && i_rd_addr[j*AW +: AW] != '0)
                    mem_d[i_rd_addr[j*AW +: AW]] = i_rd_wdata[j*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is not reset; the clear sequence initialises it.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_rs_rdata = rdata_q;
    assign o_ready    = (state_q == READY);
endmodule

// File: tb/tb_warp_xrf_mp.sv
// tb_warp_xrf_mp: directed bench for warp_xrf_mp, one instance with bypass and one without
module tb_warp_xrf_mp;
    localparam int XLEN = 64, NREGS = 32, NRD = 4, NWR = 2, AW = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NWR*AW-1:0]   rd_addr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NWR-1:0]      wen;
    logic [NRD*XLEN-1:0] rdata1, rdata0;
    logic                ready1, ready0;
    int                  n_checks = 0;
    int                  n_fail = 0;

    warp_xrf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rs_addr(rs_addr), .o_rs_rdata(rdata1),
        .i_rd_addr(rd_addr), .i_rd_wdata(wdata), .i_rd_wen(wen), .o_ready(ready1));

    warp_xrf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rs_addr(rs_addr), .o_rs_rdata(rdata0),
        .i_rd_addr(rd_addr), .i_rd_wdata(wdata), .i_rd_wen(wen), .o_ready(ready0));

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] q(input int d, input int k);
        return d ? rdata1[k*XLEN +: XLEN] : rdata0[k*XLEN +: XLEN];
    endfunction

    function automatic logic rdy(input int d);
        return d ? ready1 : ready0;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rs_addr = '0;
        rd_addr = '0;
        wdata   = '0;
        wen     = '0;
    endtask

    task automatic wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        rd_addr[j*AW +: AW]   = a;
        wdata[j*XLEN +: XLEN] = d;
        wen[j]                = 1'b1;
    endtask

    task automatic rd(input int k, input logic [AW-1:0] a);
        rs_addr[k*AW +: AW] = a;
    endtask

    // Releases reset and expects o_ready low for 30 edges and high on the 31st;
    // a write attempted on the final clear edge must be ignored.
    task automatic wait_clear;
        logic exp;
        rst_n = 1'b1;
        for (int k = 0; k < NRD; k++) rd(k, 5'd5);
        for (int i = 1; i <= 31; i++) begin
            if (i == 31) wr(0, 5'd1, 64'hBAD);
            step;
            wen = '0;
            exp = (i == 31);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (rdy(d) !== exp) begin
                    n_fail++;
                    $display("FAIL clear_ready dut%0d cycle %0d: got %b expected %b", d, i, rdy(d), exp);
                end
                if (i == 15) begin
                    n_checks++;
                    if (q(d, 0) !== '0) begin
                        n_fail++;
                        $display("FAIL clear_rdata_held dut%0d: got %h expected 0", d, q(d, 0));
                    end
                end
            end
        end
        idle;
    endtask

    task automatic test_reset;
        idle;
        rst_n = 1'b0;
        step;
        step;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (rdy(d) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready dut%0d: got %b expected 0", d, rdy(d));
            end
            for (int k = 0; k < NRD; k++) begin
                n_checks++;
                if (q(d, k) !== '0) begin
                    n_fail++;
                    $display("FAIL reset_rdata dut%0d port%0d: got %h expected 0", d, k, q(d, k));
                end
            end
        end
        wait_clear;
        for (int r = 1; r < NREGS; r += NRD) begin
            for (int k = 0; k < NRD; k++) rd(k, AW'((r + k) % NREGS));
            step;
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < NRD; k++) begin
                    n_checks++;
                    if (q(d, k) !== '0) begin
                        n_fail++;
                        $display("FAIL cleared_reg dut%0d r%0d: got %h expected 0", d, (r + k) % NREGS, q(d, k));
                    end
                end
        end
        idle;
    endtask

    task automatic test_write_read;
        wr(0, 5'd5, 64'hDEADBEEF_00000001);
        step;
        idle;
        for (int k = 0; k < NRD; k++) rd(k, 5'd5);
        step;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < NRD; k++) begin
                n_checks++;
                if (q(d, k) !== 64'hDEADBEEF_00000001) begin
                    n_fail++;
                    $display("FAIL write_read dut%0d port%0d: got %h expected deadbeef00000001", d, k, q(d, k));
                end
            end
        idle;
    endtask

    task automatic test_conflict;
        wr(0, 5'd7, 64'h11);
        wr(1, 5'd7, 64'h22);
        step;
        idle;
        rd(1, 5'd7);
        step;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (q(d, 1) !== 64'h22) begin
                n_fail++;
                $display("FAIL ww_conflict dut%0d: got %h expected 22", d, q(d, 1));
            end
        end
        idle;
    endtask

    task automatic test_bypass;
        logic [XLEN-1:0] exp;
        wr(0, 5'd9, 64'h5);
        step;
        idle;
        wr(1, 5'd9, 64'hAA);
        rd(2, 5'd9);
        step;
        wen = '0;
        for (int d = 0; d < 2; d++) begin
            exp = d ? 64'hAA : 64'h5;
            n_checks++;
            if (q(d, 2) !== exp) begin
                n_fail++;
                $display("FAIL bypass_same_cycle dut%0d: got %h expected %h", d, q(d, 2), exp);
            end
        end
        step;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (q(d, 2) !== 64'hAA) begin
                n_fail++;
                $display("FAIL bypass_next_read dut%0d: got %h expected aa", d, q(d, 2));
            end
        end
        idle;
        wr(0, 5'd11, 64'h1);
        wr(1, 5'd11, 64'h2);
        rd(0, 5'd11);
        rd(3, 5'd11);
        step;
        wen = '0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < NRD; k += 3) begin
                exp = d ? 64'h2 : 64'h0;
                n_checks++;
                if (q(d, k) !== exp) begin
                    n_fail++;
                    $display("FAIL bypass_multi dut%0d port%0d: got %h expected %h", d, k, q(d, k), exp);
                end
            end
        idle;
    endtask

    task automatic test_r0;
        wr(0, 5'd0, '1);
        wr(1, 5'd0, 64'h1234);
        rd(0, 5'd0);
        rd(3, 5'd0);
        step;
        wen = '0;
        for (int s = 0; s < 2; s++) begin
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < NRD; k += 3) begin
                    n_checks++;
                    if (q(d, k) !== '0) begin
                        n_fail++;
                        $display("FAIL r0_read dut%0d port%0d step%0d: got %h expected 0", d, k, s, q(d, k));
                    end
                end
            step;
        end
        idle;
    endtask

    task automatic test_reset_mid_clear;
        wr(0, 5'd3, 64'h33);
        step;
        idle;
        rd(0, 5'd3);
        step;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (q(d, 0) !== 64'h33) begin
                n_fail++;
                $display("FAIL r3_before_reset dut%0d: got %h expected 33", d, q(d, 0));
            end
        end
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks += 2;
            if (rdy(d) !== 1'b0) begin
                n_fail++;
                $display("FAIL async_ready_drop dut%0d: got %b expected 0", d, rdy(d));
            end
            if (q(d, 0) !== '0) begin
                n_fail++;
                $display("FAIL async_rdata_clear dut%0d: got %h expected 0", d, q(d, 0));
            end
        end
        #1;
        rst_n = 1'b1;
        repeat (9) step;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (rdy(d) !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_clear_ready dut%0d: got %b expected 0", d, rdy(d));
            end
        end
        #1;
        wait_clear;
        rd(0, 5'd3);
        rd(1, 5'd1);
        step;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (q(d, k) !== '0) begin
                    n_fail++;
                    $display("FAIL reg_after_reclear dut%0d port%0d: got %h expected 0", d, k, q(d, k));
                end
            end
        idle;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_conflict;
        test_bypass;
        test_r0;
        test_reset_mid_clear;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
